fetch_stage: RTL

Instruction-fetch stage of the 16-bit processor. It owns the program counter and drives the word address into the asynchronous-read instruction memory. It captures the returned 16-bit instruction into the IF/ID pipeline register for decode, and handles stall, redirect (BEQ taken / JALR) and halt.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/fetch_stage_if.sv | 7 +
 rtl/if_id_reg.sv | 37 +++
 rtl/fetch_stage.sv | 64 ++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, opcodes and fetch FSM encoding for the 16-bit processor
package cpu_pkg;
  localparam int ADDR_W = 10;
  localparam int INSTR_W = 16;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_SUBI = 3'b010;
  localparam logic [2:0] OP_BEQ = 3'b011;
  localparam logic [2:0] OP_JALR = 3'b100;
  localparam logic [2:0] OP_LUI = 3'b101;
  localparam logic [2:0] OP_SW = 3'b110;
  localparam logic [15:0] NOP_INSTR = 16'h0000;
  typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_t;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: asynchronous-read instruction memory port
interface fetch_stage_if #(parameter int ADDR_W = cpu_pkg::ADDR_W, parameter int INSTR_W = cpu_pkg::INSTR_W);
  logic [ADDR_W-1:0] imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  modport master (output imem_addr, input imem_instr);
  modport slave (input imem_addr, output imem_instr);
endinterface

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load, hold and flush-to-NOP
module if_id_reg #(
  parameter int ADDR_W = 10,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               flush,
  input  logic [INSTR_W-1:0] instr,
  input  logic [ADDR_W-1:0]  pc,
  output logic               valid,
  output logic [INSTR_W-1:0] instr_q,
  output logic [2:0]         opcode,
  output logic [ADDR_W-1:0]  pc_q,
  output logic [ADDR_W-1:0]  pc_next
);
  import cpu_pkg::*;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid <= 1'b0;
      instr_q <= '0;
      opcode <= '0;
      pc_q <= '0;
      pc_next <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      instr_q <= INSTR_W'(NOP_INSTR);
      opcode <= '0;
    end else if (load) begin
      valid <= 1'b1;
      instr_q <= instr;
      opcode <= instr[INSTR_W-1 -: 3];
      pc_q <= pc;
      pc_next <= ADDR_W'(pc + 1'b1);
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, fetches from imem and fills IF/ID; handles stall, redirect and halt
module fetch_stage #(
  parameter int ADDR_W = 10,
  parameter int INSTR_W = 16,
  parameter int RESET_PC = 0,
  parameter int LAST_PC = 1023
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_stage_if.master      imem,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  input  logic               halt_i,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               ifid_valid_o,
  output logic [INSTR_W-1:0] ifid_instr_o,
  output logic [2:0]         ifid_opcode_o,
  output logic [ADDR_W-1:0]  ifid_pc_o,
  output logic [ADDR_W-1:0]  ifid_pc_next_o,
  output logic               halted_o,
  output logic [15:0]        fetch_count_o
);
  import cpu_pkg::*;
  fetch_state_t state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx;
  logic run, capture, flush;
  assign run = state == RUN;
  assign capture = run && !halt_i && !redirect_i && !stall_i;
  // HALT keeps flushing so the register reads as a NOP bubble forever
  assign flush = state == HALT || (run && (halt_i || redirect_i));
  always_comb begin
    state_nx = state == BOOT ? (halt_i ? HALT : RUN) :
               (run && (halt_i || (capture && pc == ADDR_W'(LAST_PC)))) ? HALT : state;
    pc_nx = (run && !halt_i && redirect_i) ? redirect_pc_i :
            capture ? ADDR_W'(pc + 1'b1) : pc;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= BOOT;
      pc <= ADDR_W'(RESET_PC);
      fetch_count_o <= '0;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      if (capture && fetch_count_o != 16'hFFFF) fetch_count_o <= fetch_count_o + 16'd1;
    end
  if_id_reg #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_ifid (
    .clk(clk),
    .rst_n(rst_n),
    .load(capture),
    .flush(flush),
    .instr(imem.imem_instr),
    .pc(pc),
    .valid(ifid_valid_o),
    .instr_q(ifid_instr_o),
    .opcode(ifid_opcode_o),
    .pc_q(ifid_pc_o),
    .pc_next(ifid_pc_next_o)
  );
  assign imem.imem_addr = pc;
  assign pc_o = pc;
  assign halted_o = state == HALT;
endmodule
